// File: rtl/axis_burst_scheduler.sv
// axis_burst_scheduler: triggered burst framer for a free-running AXI4-Stream source.
// Drops pre-delay and inter-packet gap samples, forwards npkt packets of len beats with tlast.
module axis_burst_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int PKT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_len,
  input  logic [CNTR_WIDTH-1:0]       cfg_delay,
  input  logic [CNTR_WIDTH-1:0]       cfg_gap,
  input  logic [PKT_WIDTH-1:0]        cfg_npkt,
  input  logic                        trg_flag,
  output logic                        busy,
  output logic [PKT_WIDTH-1:0]        sts_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);
  typedef enum logic [1:0] {IDLE, DELAY, STREAM, GAP} state_t;
  state_t                state_q;
  logic                  trg_q;
  logic [CNTR_WIDTH-1:0] cnt_q, len_q, delay_q, gap_q;
  logic [PKT_WIDTH-1:0]  pkt_q, npkt_q;
  logic                  rise, stream, last, xfer, drop_done;
  logic [CNTR_WIDTH-1:0] drop_len;
  logic [PKT_WIDTH-1:0]  pkt_d;
  assign rise      = trg_flag & ~trg_q;
  assign stream    = state_q == STREAM;
  assign last      = cnt_q == len_q - CNTR_WIDTH'(1);
  assign xfer      = stream & s_axis_tvalid & m_axis_tready;
  assign drop_len  = state_q == DELAY ? delay_q : gap_q;
  assign drop_done = cnt_q == drop_len - CNTR_WIDTH'(1);
  assign pkt_d     = pkt_q + PKT_WIDTH'(1);
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      trg_q   <= 1'b0;
      cnt_q   <= '0;
      pkt_q   <= '0;
      len_q   <= '0;
      delay_q <= '0;
      gap_q   <= '0;
      npkt_q  <= '0;
    end else begin
      trg_q <= trg_flag;
      case (state_q)
        IDLE: if (rise && cfg_len != '0 && cfg_npkt != '0) begin
          len_q   <= cfg_len;
          delay_q <= cfg_delay;
          gap_q   <= cfg_gap;
          npkt_q  <= cfg_npkt;
          cnt_q   <= '0;
          pkt_q   <= '0;
          state_q <= cfg_delay != '0 ? DELAY : STREAM;
        end
        DELAY, GAP: if (s_axis_tvalid) begin
          cnt_q   <= drop_done ? '0 : cnt_q + CNTR_WIDTH'(1);
          state_q <= drop_done ? STREAM : state_q;
        end
        STREAM: if (xfer) begin
          cnt_q <= last ? '0 : cnt_q + CNTR_WIDTH'(1);
          if (last) begin
            pkt_q   <= pkt_d;
            state_q <= pkt_d == npkt_q ? IDLE : gap_q != '0 ? GAP : STREAM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Outside STREAM the source is always drained so it never stalls.
  assign s_axis_tready = stream ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = stream & s_axis_tvalid;
  assign m_axis_tlast  = stream & last;
  assign m_axis_tdata  = s_axis_tdata;
  assign busy          = state_q != IDLE;
  assign sts_data      = pkt_q;
endmodule

// File: tb/tb_axis_burst_scheduler.sv
// tb_axis_burst_scheduler: directed and randomized bursts checked against an arithmetic
// model of which consumed source samples must appear on the master side.
module tb_axis_burst_scheduler;
  localparam int DW = 32, CW = 32, PW = 16;
  logic          aclk = 1'b0, aresetn = 1'b0;
  logic [CW-1:0] cfg_len = '0, cfg_delay = '0, cfg_gap = '0;
  logic [PW-1:0] cfg_npkt = '0, sts_data;
  logic          trg_flag = 1'b0, busy;
  logic          s_axis_tready, s_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b1, m_axis_tvalid, m_axis_tlast;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  int            n_assert = 0, n_fail = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [PW-1:0] exp_sts = '0;
  bit            chk_en = 1'b0, hs = 1'b0;
  int            vmode = 0, rmode = 0;
  always #5 aclk = ~aclk;
  axis_burst_scheduler #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .PKT_WIDTH(PW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_len(cfg_len), .cfg_delay(cfg_delay),
    .cfg_gap(cfg_gap), .cfg_npkt(cfg_npkt), .trg_flag(trg_flag), .busy(busy),
    .sts_data(sts_data), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Source holds data while stalled, so consumed samples are consecutive integers.
  task automatic tick();
    @(negedge aclk);
    hs = s_axis_tvalid && s_axis_tready;
    @(posedge aclk);
    #1;
    if (hs) s_axis_tdata++;
    if (!s_axis_tvalid || hs) s_axis_tvalid = vmode == 0 ? 1'b1 : $urandom_range(0, 3) != 0;
    m_axis_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_axis_tready : 1'($urandom_range(0, 1));
  endtask
  task automatic fire(input int len, input int dly, input int gap, input int npkt);
    cfg_len = CW'(len); cfg_delay = CW'(dly); cfg_gap = CW'(gap); cfg_npkt = PW'(npkt);
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    exp_sts = '0;
    got_q.delete();
    for (int p = 0; p < npkt; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back({1'(i == len - 1), DW'(s_axis_tdata + DW'(dly + p * (len + gap) + i))});
  endtask
  task automatic drain(input int npkt, input string tag);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_sts"}, sts_data, npkt);
    exp_q.delete();
  endtask
  always @(negedge aclk) if (chk_en) begin
    logic [DW:0] e;
    chk("sts_data", sts_data, exp_sts);
    if (!busy) begin
      chk("idle_mvalid", m_axis_tvalid, 0);
      chk("idle_sready", s_axis_tready, 1);
    end
    if (m_axis_tvalid) chk("tready_mirror", s_axis_tready, m_axis_tready);
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(m_axis_tdata);
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tdata", m_axis_tdata, e[DW-1:0]);
        chk("tlast", m_axis_tlast, e[DW]);
        if (e[DW]) exp_sts++;
      end
    end
  end
  initial begin
    int n;
    s_axis_tvalid = 1'b1;
    repeat (3) tick();
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mlast", m_axis_tlast, 0);
    chk("rst_sready", s_axis_tready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sts", sts_data, 0);
    aresetn = 1'b1;
    chk_en = 1'b1;
    n = 0;
    while (s_axis_tdata != 10 && n < 50) begin tick(); n++; end
    fire(4, 2, 3, 2);
    drain(2, "basic");
    chk("basic_nbeats", got_q.size(), 8);
    if (got_q.size() == 8) begin
      chk("basic_first", got_q[0], 13);
      chk("basic_p0_last", got_q[3], 16);
      chk("basic_p1_first", got_q[4], 20);
      chk("basic_p1_last", got_q[7], 23);
    end
    fire(1, 0, 0, 3);
    drain(3, "single");
    rmode = 1;
    fire(4, 0, 0, 1);
    drain(1, "backpressure");
    rmode = 0;
    fire(4, 1, 2, 2);
    repeat (3) tick();
    cfg_len = CW'(8);
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    drain(2, "cfg_change");
    cfg_len = '0;
    trg_flag = 1'b1;
    tick();
    trg_flag = 1'b0;
    repeat (3) begin tick(); chk("len0_busy", busy, 0); end
    fire(4, 1, 0, 2);
    n = 0;
    while (got_q.size() < 1 && n < 50) begin tick(); n++; end
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    exp_q.delete();
    exp_sts = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_mvalid", m_axis_tvalid, 0);
    fire(4, 1, 0, 2);
    drain(2, "post_reset");
    vmode = 1;
    rmode = 2;
    for (int k = 0; k < 8; k++) begin
      int np = $urandom_range(1, 3);
      fire($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3), np);
      drain(np, "random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_burst_scheduler.md
Name: axis_burst_scheduler

Overview:
Controller that sequences a free-running ADC-style AXI4-Stream into a triggered burst of packets. After a trigger it discards a programmable number of pre-delay samples, then forwards cfg_npkt packets of cfg_len samples each, asserting tlast on the final beat of every packet. A programmable number of samples is dropped between packets. It sits between the sample source and the DMA/FIFO writer and replaces manual start/stop sequencing of the packet framer.

Parameters:
AXIS_TDATA_WIDTH, 32, data width of both stream sides.
CNTR_WIDTH, 32, width of the length, delay and gap counters.
PKT_WIDTH, 16, width of the packet counter and of cfg_npkt.

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
cfg_len  input  CNTR_WIDTH  samples per packet
cfg_delay  input  CNTR_WIDTH  samples discarded after trigger
cfg_gap  input  CNTR_WIDTH  samples discarded between packets
cfg_npkt  input  PKT_WIDTH  packets per burst
trg_flag  input  1  trigger level; rising edge starts a burst
busy  output  1  high whenever state is not IDLE
sts_data  output  PKT_WIDTH  packets completed in the current or last burst
s_axis_tready  output  1  slave ready
s_axis_tdata  input  AXIS_TDATA_WIDTH  slave data
s_axis_tvalid  input  1  slave valid
m_axis_tready  input  1  master ready
m_axis_tdata  output  AXIS_TDATA_WIDTH  master data, equal to s_axis_tdata
m_axis_tvalid  output  1  master valid
m_axis_tlast  output  1  last beat of packet

Behaviour:
- Reset: aresetn is synchronous and active-low on clock aclk. Reset forces state IDLE, all counters to 0 and the trigger edge register to 0. After reset: busy=0, sts_data=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1.
- Trigger: trg_flag is registered; rise = trg_flag & ~trg_reg. A rise is accepted only in IDLE with cfg_len!=0 and cfg_npkt!=0; otherwise it is ignored.
- On an accepted rise: latch cfg_len, cfg_delay, cfg_gap and cfg_npkt into shadow registers. Config changes during a burst have no effect. Clear sts_data and the beat counter.
- States and transitions:
  - IDLE -> DELAY on accepted rise if latched delay != 0; else IDLE -> STREAM.
  - DELAY: s_axis_tready=1 and samples are dropped. Count on each s_axis_tvalid. When the counter reaches delay-1 with tvalid, clear the counter and go to STREAM.
  - STREAM: s_axis_tready=m_axis_tready and m_axis_tvalid=s_axis_tvalid, both combinational with zero latency. A beat transfers when s_axis_tvalid & m_axis_tready. m_axis_tlast = (cnt == len-1) while in STREAM.
    - On a last-beat transfer, sts_data increments. If sts_data+1 == npkt, go to IDLE. Otherwise go to GAP if gap != 0, else start the next packet in STREAM with the counter cleared.
  - GAP: same drop/count rule as DELAY using gap, then return to STREAM.
- Outside STREAM: m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1, so the source is never stalled.
- Counters: compare with ==; no wrap is possible because latched lengths bound them. len=1 gives tlast on every beat.
- Simultaneous events:
  - A rise in the same cycle as the final transfer is ignored, because the state is not yet IDLE.
  - A rise on the cycle after return to IDLE is accepted.
- Reset mid-burst: immediately returns to IDLE. A partial packet is abandoned without tlast; downstream handles this.
- sts_data holds its value after a burst completes, until the next accepted trigger.

Test Plan:
1. Reset behaviour: assert aresetn=0 for 3 cycles with s_axis_tvalid=1 -> m_axis_tvalid=0, s_axis_tready=1, busy=0, sts_data=0.
2. Basic burst: cfg_len=4, delay=2, gap=3, npkt=2, continuous tvalid with data 0,1,2,…, m_axis_tready=1, trigger at sample 10 -> output 13,14,15,16 (tlast on 16), then 20,21,22,23 (tlast on 23); sts_data=2, busy falls after beat 23.
3. Zero delay and gap: cfg_len=1, delay=0, gap=0, npkt=3 -> three consecutive single-beat packets, each with tlast=1; sts_data steps 1,2,3.
4. Backpressure: m_axis_tready toggled 1,0,1,0 during STREAM -> s_axis_tready mirrors m_axis_tready; no beat is lost or duplicated; tlast appears only on the 4th accepted beat.
5. Re-trigger and config change: trigger pulse mid-burst and cfg_len changed to 8 mid-burst -> both ignored; the burst completes with len=4. A new trigger with cfg_len=0 -> busy stays 0.
6. Reset mid-burst: reset during beat 2 of packet 1 -> next cycle busy=0 and m_axis_tvalid=0. A subsequent trigger produces a full, correct burst.
